branch_target_predictor: RTL
============================

// Module: branch_target_predictor
// PURPOSE
//  Parametrised fetch-stage predictor: direct-mapped BTB plus 2-bit saturating counters.
//  Fetch redirects early on predicted-taken branches and jumps, instead of always fetching
//  pc+4 and flushing when MEM resolves. Sits beside the PC register: lookup uses the current
//  fetch PC; update and mispredict detection use the resolved branch/jump in MEM.
// PARAMETERS
//  PC_WIDTH   32  width of all PC/target buses
//  ENTRIES    16  BTB entries; power of two, >=2; IDX_W = log2(ENTRIES)
//  CNT_WIDTH  16  width of the saturating performance counters
// PORTS
//  clk              in   1         clock, rising edge
//  rst              in   1         asynchronous, active-high reset
//  if_pc            in   PC_WIDTH  current fetch PC
//  pred_hit         out  1         valid BTB entry with matching tag for if_pc
//  pred_taken       out  1         hit & (jump entry | counter MSB set)
//  pred_next_pc     out  PC_WIDTH  pred_taken ? stored target : if_pc+4
//  upd_valid        in   1         MEM holds a resolved branch or jump this cycle
//  upd_is_jump      in   1         resolved instruction is jal/jalr (1) or conditional branch (0)
//  upd_pc           in   PC_WIDTH  PC of the resolved instruction
//  upd_taken        in   1         actual outcome (1 for jumps)
//  upd_target       in   PC_WIDTH  actual target address
//  upd_pred_taken   in   1         prediction carried down the pipeline with the instruction
//  upd_pred_target  in   PC_WIDTH  predicted next PC carried down the pipeline
//  redirect_valid   out  1         misprediction; flush IF/ID/EX and load redirect_pc
//  redirect_pc      out  PC_WIDTH  correct next PC
//  flush_btb        in   1         invalidate all entries (fence.i / satp write)
//  perf_branches    out  CNT_WIDTH resolved branches+jumps count, saturating
//  perf_mispredicts out  CNT_WIDTH redirect count, saturating
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst asynchronous, active-high.
//  - Index/tag:
//    - index = pc[IDX_W+1:2]; tag = pc[PC_WIDTH-1:IDX_W+2].
//    - pc[1:0] ignored.
//  - Entry contents: {valid, is_jump, tag, target, cnt[1:0]}.
//  - Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
//  - Lookup:
//    - Combinational from stored state, zero latency, same cycle as if_pc.
//    - Table written only on the clk edge, so a same-cycle update to the same index is not
//      visible until the next cycle.
//  - Redirect (combinational from upd_* inputs):
//    - redirect_valid = upd_valid & (upd_taken != upd_pred_taken
//                                    | (upd_taken & upd_target != upd_pred_target)).
//    - redirect_pc = upd_taken ? upd_target : upd_pc+4.
//    - pc+4 wraps modulo 2^PC_WIDTH.
//  - Update on clk edge when upd_valid:
//    - Tag hit, branch: counter increments if taken, decrements if not; saturates at ST/SNT.
//      Target overwritten if taken.
//    - Tag hit, jump: target overwritten (jalr learns the last target); cnt=ST.
//    - Miss, taken: allocate and overwrite the index.
//      - Valid=1, is_jump=upd_is_jump, tag, target.
//      - cnt = jump ? ST : WT.
//    - Miss, not taken: no allocation, table unchanged.
//  - flush_btb: clears every valid bit on the next edge. Counters and targets are kept.
//    Flush wins over a same-cycle update.
//  - Perf counters:
//    - perf_branches += upd_valid.
//    - perf_mispredicts += redirect_valid.
//    - Both hold at all-ones; neither is cleared by flush_btb.
//  - Reset values:
//    - All valid=0, cnt=WNT, targets=0, perf counters=0.
//    - With the table empty: pred_hit=0, pred_taken=0, pred_next_pc=if_pc+4.
//    - redirect_valid=0 while upd_valid=0.
//  - Reset mid-operation: table and counters clear asynchronously. Outputs reflect the empty
//    table immediately; no partial update is committed.
//  - No stall input: the caller holds if_pc stable; lookup is stateless and may repeat.
// STRUCTURE
//  - Shared package bp_pkg:
//    - Counter encodings SNT/WNT/WT/ST.
//    - Entry struct/width constants.
//    - Function cnt_next(cnt, taken).
//  - Sub-module bp_sat_counter (CNT_WIDTH saturating incrementer), instantiated twice for
//    perf counters.
//  - Table as flop arrays (small ENTRIES); no RAM macro.
// TESTING
//  1. Reset, ENTRIES=16.
//     - if_pc=0x100 -> pred_hit=0, pred_next_pc=0x104.
//     - Both perf counters read 0.
//  2. Update pc=0x100, branch, taken, target=0x80, pred_taken=0.
//     - Same cycle: redirect_valid=1, redirect_pc=0x80.
//     - Next cycle: if_pc=0x100 -> hit, taken, next=0x80 (cnt=WT).
//  3. Two not-taken updates at 0x100.
//     - Counter walks WT->WNT->SNT; lookup then gives taken=0, next=0x104.
//     - A third not-taken update stays SNT.
//  4. Alias 0x140 (same index, different tag): jal to 0x200 replaces the entry.
//     - 0x100 then misses; 0x140 predicts 0x200.
//     - jalr retarget to 0x300 with pred_target=0x200 -> redirect_valid=1 to 0x300.
//  5. flush_btb and an update in the same cycle -> all lookups miss afterwards.
//     - perf_branches still incremented.
//  6. Drive 2^CNT_WIDTH+3 mispredicts (CNT_WIDTH=4 build) -> perf_mispredicts sticks at 0xF.
//     - Assert rst mid-stream -> counters and hits clear immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor.
package bp_pkg;

    localparam int unsigned CNT_BITS = 2;

    // Two-bit direction counter states.
    typedef enum logic [CNT_BITS-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Per-entry control bits; tag and target live in separate flop arrays
    // because their widths depend on the top-level parameters.
    typedef struct packed {
        logic valid;
        logic is_jump;
        cnt_e cnt;
    } entry_meta_t;

    localparam int unsigned META_W = $bits(entry_meta_t);

    // Saturating step of the two-bit direction counter.
    function automatic cnt_e cnt_next(input cnt_e cnt, input logic taken);
        cnt_e nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt_e'(CNT_BITS'(cnt) + CNT_BITS'(1));
        end else begin
            if (cnt != SNT) nxt = cnt_e'(CNT_BITS'(cnt) - CNT_BITS'(1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events until the counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with 2-bit direction counters,
// mispredict detection for the resolved branch in MEM, and perf counters.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_next_pc,
    input  logic                 upd_valid,
    input  logic                 upd_is_jump,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic                 upd_pred_taken,
    input  logic [PC_WIDTH-1:0]  upd_pred_target,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic                 flush_btb,
    output logic [CNT_WIDTH-1:0] perf_branches,
    output logic [CNT_WIDTH-1:0] perf_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_WIDTH - IDX_W - 2;

    entry_meta_t         meta_q   [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    logic [IDX_W-1:0]    if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    entry_meta_t         if_meta;
    entry_meta_t         upd_meta;

    // Split both PCs into index and tag; the byte offset is ignored.
    always_comb begin
        if_idx   = if_pc[IDX_W+1:2];
        if_tag   = if_pc[PC_WIDTH-1:IDX_W+2];
        upd_idx  = upd_pc[IDX_W+1:2];
        upd_tag  = upd_pc[PC_WIDTH-1:IDX_W+2];
        if_meta  = meta_q[if_idx];
        upd_meta = meta_q[upd_idx];
        upd_hit  = upd_meta.valid && (tag_q[upd_idx] == upd_tag);
    end

    // Zero-latency lookup for the current fetch PC.
    always_comb begin
        pred_hit     = if_meta.valid && (tag_q[if_idx] == if_tag);
        pred_taken   = pred_hit && (if_meta.is_jump || if_meta.cnt[CNT_BITS-1]);
        pred_next_pc = pred_taken ? target_q[if_idx] : if_pc + PC_WIDTH'(4);
    end

    // Resolved outcome vs. the prediction that travelled with the instruction.
    always_comb begin
        redirect_valid = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc    = upd_taken ? upd_target : upd_pc + PC_WIDTH'(4);
    end

    // Table training; flush takes priority over a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                meta_q[IDX_W'(i)]   <= '{valid: 1'b0, is_jump: 1'b0, cnt: WNT};
                tag_q[IDX_W'(i)]    <= '0;
                target_q[IDX_W'(i)] <= '0;
            end
        end else if (flush_btb) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                meta_q[IDX_W'(i)].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_is_jump) begin
                    // Jumps always go; keep the latest target so jalr follows it.
                    meta_q[upd_idx].cnt <= ST;
                    target_q[upd_idx]   <= upd_target;
                end else begin
                    meta_q[upd_idx].cnt <= cnt_next(upd_meta.cnt, upd_taken);
                    if (upd_taken) begin
                        target_q[upd_idx] <= upd_target;
                    end
                end
            end else if (upd_taken) begin
                // Allocate, evicting whatever aliased into this index.
                meta_q[upd_idx]   <= '{valid: 1'b1, is_jump: upd_is_jump,
                                       cnt: (upd_is_jump ? ST : WT)};
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
            end
        end
    end

    bp_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_perf_branches (
        .clk   (clk),
        .rst   (rst),
        .inc   (upd_valid),
        .count (perf_branches)
    );

    bp_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_perf_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_valid),
        .count (perf_mispredicts)
    );

endmodule
